router_fsm_n: RTL and testbench

Parametrised packet-router control FSM for the 1xN router. It sequences header decode, payload load, FIFO-full stall, parity load and parity check for one input stream feeding NUM_PORTS output FIFOs. Compared with the fixed 1x3 controller, it adds:
- a configurable port count and address width;
- an address latched at header time and used for all later port selection;
- a drop mode for packets with an invalid address;
- a bounded WAIT_TILL_EMPTY timeout.

---
 rtl/router_fsm_n.sv | 136 +++++++++++++
 tb/tb_router_fsm_n.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/router_fsm_n.sv
// Packet-router control FSM for a 1xN router: header decode, payload load, full stall,
// parity load/check, bounded wait for an empty FIFO, and discard of invalid-address packets.
module router_fsm_n #(
   parameter int unsigned NUM_PORTS    = 3,
   parameter int unsigned ADDR_W       = 2,
   parameter int unsigned WAIT_TIMEOUT = 32
) (
   input  logic                 clock,
   input  logic                 resetn,
   input  logic                 pkt_valid,
   input  logic [ADDR_W-1:0]    data_in,
   input  logic                 fifo_full,
   input  logic [NUM_PORTS-1:0] fifo_empty,
   input  logic [NUM_PORTS-1:0] soft_reset,
   input  logic                 parity_done,
   input  logic                 low_packet_valid,
   output logic                 detect_add,
   output logic                 lfd_state,
   output logic                 ld_state,
   output logic                 full_state,
   output logic                 laf_state,
   output logic                 rst_int_reg,
   output logic                 write_enb_reg,
   output logic                 busy,
   output logic                 drop_state,
   output logic [ADDR_W-1:0]    cur_addr,
   output logic                 addr_err,
   output logic                 timeout_err
);

   localparam int unsigned CntW = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;
   localparam int unsigned PadW = (1 << ADDR_W) - NUM_PORTS;
   localparam logic [CntW-1:0]   CntLast   = CntW'((WAIT_TIMEOUT > 0) ? WAIT_TIMEOUT - 1 : 0);
   localparam logic [ADDR_W-1:0] NumPortsA = ADDR_W'(NUM_PORTS);

   typedef enum logic [3:0] {
      StDecode        = 4'd0,
      StLoadFirst     = 4'd1,
      StLoadData      = 4'd2,
      StFifoFull      = 4'd3,
      StLoadAfterFull = 4'd4,
      StLoadParity    = 4'd5,
      StCheckParity   = 4'd6,
      StWaitEmpty     = 4'd7,
      StDrop          = 4'd8
   } state_e;

   state_e              state_q, state_d, next_state;
   logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
   logic [CntW-1:0]     wait_cnt_q, wait_cnt_d;
   logic                addr_err_q, addr_err_d;
   logic                timeout_err_q, timeout_err_d;
   logic                timeout_hit;

   // Zero-padded to the full address space so out-of-range addresses read as 0.
   logic [(1<<ADDR_W)-1:0] empty_pad, soft_pad;
   assign empty_pad = {{PadW{1'b0}}, fifo_empty};
   assign soft_pad  = {{PadW{1'b0}}, soft_reset};

   assign timeout_hit = (WAIT_TIMEOUT != 0) && (wait_cnt_q == CntLast);

   always_comb begin
      next_state = StDecode;
      case (state_q)
         StDecode: begin
            if (!pkt_valid)                   next_state = StDecode;
            else if (data_in >= NumPortsA)    next_state = StDrop;
            else if (empty_pad[data_in])      next_state = StLoadFirst;
            else                              next_state = StWaitEmpty;
         end
         StWaitEmpty: begin
            if (empty_pad[cur_addr_q])        next_state = StLoadFirst;
            else if (timeout_hit)             next_state = StDrop;
            else                              next_state = StWaitEmpty;
         end
         StLoadFirst:                         next_state = StLoadData;
         StLoadData: begin
            if (fifo_full)                    next_state = StFifoFull;
            else if (!pkt_valid)              next_state = StLoadParity;
            else                              next_state = StLoadData;
         end
         StFifoFull:       next_state = fifo_full ? StFifoFull : StLoadAfterFull;
         StLoadAfterFull: begin
            if (parity_done)                  next_state = StDecode;
            else if (low_packet_valid)        next_state = StLoadParity;
            else                              next_state = StLoadData;
         end
         StLoadParity:                        next_state = StCheckParity;
         StCheckParity:    next_state = fifo_full ? StFifoFull : StDecode;
         StDrop:           next_state = pkt_valid ? StDrop : StDecode;
         default:                             next_state = StDecode;
      endcase
   end

   always_comb begin
      state_d       = soft_pad[cur_addr_q] ? StDecode : next_state;
      cur_addr_d    = (state_q == StDecode && pkt_valid) ? data_in : cur_addr_q;
      // Counter holds the number of WAIT cycles already completed; 0 outside WAIT.
      wait_cnt_d    = '0;
      if (state_q == StWaitEmpty && state_d == StWaitEmpty) begin
         wait_cnt_d = (wait_cnt_q == CntLast) ? wait_cnt_q : wait_cnt_q + CntW'(1);
      end
      addr_err_d    = (state_q == StDecode)    && (state_d == StDrop);
      timeout_err_d = (state_q == StWaitEmpty) && (state_d == StDrop);
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q       <= StDecode;
         cur_addr_q    <= '1;
         wait_cnt_q    <= '0;
         addr_err_q    <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cur_addr_q    <= cur_addr_d;
         wait_cnt_q    <= wait_cnt_d;
         addr_err_q    <= addr_err_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign detect_add    = (state_q == StDecode);
   assign lfd_state     = (state_q == StLoadFirst);
   assign ld_state      = (state_q == StLoadData);
   assign full_state    = (state_q == StFifoFull);
   assign laf_state     = (state_q == StLoadAfterFull);
   assign rst_int_reg   = (state_q == StCheckParity);
   assign drop_state    = (state_q == StDrop);
   assign write_enb_reg = ld_state | laf_state | (state_q == StLoadParity);
   assign busy          = !(detect_add | ld_state | drop_state);
   assign cur_addr      = cur_addr_q;
   assign addr_err      = addr_err_q;
   assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_router_fsm_n.sv
// Directed bench for router_fsm_n: each step queues the expected post-edge outputs,
// and the entry is popped and compared one edge later.
module tb_router_fsm_n;

   logic       clock = 1'b0;
   logic       resetn;
   logic       pkt_valid;
   logic [1:0] data_in;
   logic       fifo_full;
   logic [2:0] fifo_empty;
   logic [2:0] soft_reset;
   logic       parity_done;
   logic       low_packet_valid;
   logic       detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg;
   logic       write_enb_reg, busy, drop_state, addr_err, timeout_err;
   logic [1:0] cur_addr;

   always #5 clock = ~clock;

   router_fsm_n #(
      .NUM_PORTS   (3),
      .ADDR_W      (2),
      .WAIT_TIMEOUT(8)
   ) dut (
      .clock           (clock),
      .resetn          (resetn),
      .pkt_valid       (pkt_valid),
      .data_in         (data_in),
      .fifo_full       (fifo_full),
      .fifo_empty      (fifo_empty),
      .soft_reset      (soft_reset),
      .parity_done     (parity_done),
      .low_packet_valid(low_packet_valid),
      .detect_add      (detect_add),
      .lfd_state       (lfd_state),
      .ld_state        (ld_state),
      .full_state      (full_state),
      .laf_state       (laf_state),
      .rst_int_reg     (rst_int_reg),
      .write_enb_reg   (write_enb_reg),
      .busy            (busy),
      .drop_state      (drop_state),
      .cur_addr        (cur_addr),
      .addr_err        (addr_err),
      .timeout_err     (timeout_err)
   );

   typedef struct {
      int         st;
      logic [1:0] addr;
      logic       ae;
      logic       te;
      string      tag;
   } exp_t;

   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   // {detect, lfd, ld, full, laf, rst_int, drop, write_enb, busy} for a state code
   function automatic logic [8:0] exp_vec(input int st);
      logic we, bz;
      we = (st == 2) || (st == 4) || (st == 5);
      bz = !((st == 0) || (st == 2) || (st == 8));
      return {st == 0, st == 1, st == 2, st == 3, st == 4, st == 6, st == 8, we, bz};
   endfunction

   task automatic step(input int st, input logic [1:0] addr, input logic ae, input logic te,
                       input string tag);
      exp_t e;
      logic [8:0] obs;
      sb.push_back('{st, addr, ae, te, tag});
      @(posedge clock);
      #1;
      e   = sb.pop_front();
      obs = {detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg, drop_state,
             write_enb_reg, busy};
      n_cmp++;
      assert (obs === exp_vec(e.st)) else begin
         n_fail++;
         $error("FAIL %s decodes: observed %b expected %b", e.tag, obs, exp_vec(e.st));
      end
      n_cmp++;
      assert (cur_addr === e.addr) else begin
         n_fail++;
         $error("FAIL %s cur_addr: observed %0d expected %0d", e.tag, cur_addr, e.addr);
      end
      n_cmp++;
      assert (addr_err === e.ae) else begin
         n_fail++;
         $error("FAIL %s addr_err: observed %b expected %b", e.tag, addr_err, e.ae);
      end
      n_cmp++;
      assert (timeout_err === e.te) else begin
         n_fail++;
         $error("FAIL %s timeout_err: observed %b expected %b", e.tag, timeout_err, e.te);
      end
   endtask

   initial begin
      resetn = 1'b0; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
      fifo_empty = 3'b111; soft_reset = 3'b000; parity_done = 1'b0; low_packet_valid = 1'b0;
      step(0, 2'd3, 0, 0, "reset0");
      step(0, 2'd3, 0, 0, "reset1");
      resetn = 1'b1;
      step(0, 2'd3, 0, 0, "idle");

      // Normal packet to port 2
      pkt_valid = 1'b1; data_in = 2'd2;
      step(1, 2'd2, 0, 0, "norm_lfd");
      data_in = 2'd0;
      step(2, 2'd2, 0, 0, "norm_ld0");
      for (int i = 0; i < 3; i++) step(2, 2'd2, 0, 0, "norm_ld");
      pkt_valid = 1'b0;
      step(5, 2'd2, 0, 0, "norm_lp");
      step(6, 2'd2, 0, 0, "norm_cpe");
      step(0, 2'd2, 0, 0, "norm_done");

      // Full stall on port 1
      pkt_valid = 1'b1; data_in = 2'd1;
      step(1, 2'd1, 0, 0, "full_lfd");
      step(2, 2'd1, 0, 0, "full_ld");
      fifo_full = 1'b1;
      for (int i = 0; i < 3; i++) step(3, 2'd1, 0, 0, "full_stall");
      fifo_full = 1'b0;
      step(4, 2'd1, 0, 0, "full_laf");
      step(2, 2'd1, 0, 0, "full_back_ld");
      pkt_valid = 1'b0;
      step(5, 2'd1, 0, 0, "full_lp");
      step(6, 2'd1, 0, 0, "full_cpe");
      step(0, 2'd1, 0, 0, "full_done");

      // Full beats end-of-packet in LOAD_DATA; parity_done beats low_packet_valid
      pkt_valid = 1'b1; data_in = 2'd0;
      step(1, 2'd0, 0, 0, "pri_lfd");
      step(2, 2'd0, 0, 0, "pri_ld");
      pkt_valid = 1'b0; fifo_full = 1'b1;
      step(3, 2'd0, 0, 0, "pri_full");
      fifo_full = 1'b0;
      step(4, 2'd0, 0, 0, "pri_laf");
      parity_done = 1'b1; low_packet_valid = 1'b1;
      step(0, 2'd0, 0, 0, "pri_pd");
      parity_done = 1'b0; low_packet_valid = 1'b0;

      // Invalid address 3 is dropped
      pkt_valid = 1'b1; data_in = 2'd3;
      step(8, 2'd3, 1, 0, "drop_enter");
      for (int i = 0; i < 5; i++) step(8, 2'd3, 0, 0, "drop_hold");
      pkt_valid = 1'b0;
      step(0, 2'd3, 0, 0, "drop_exit");

      // Wait timeout: port 1 never empties
      fifo_empty = 3'b101; pkt_valid = 1'b1; data_in = 2'd1;
      step(7, 2'd1, 0, 0, "wait_enter");
      for (int i = 0; i < 7; i++) step(7, 2'd1, 0, 0, "wait_hold");
      step(8, 2'd1, 0, 1, "wait_timeout");
      step(8, 2'd1, 0, 0, "wait_drop2");
      pkt_valid = 1'b0;
      step(0, 2'd1, 0, 0, "wait_exit");

      // Port empties on the last wait cycle: empty wins over expiry
      pkt_valid = 1'b1;
      step(7, 2'd1, 0, 0, "wait2_enter");
      for (int i = 0; i < 7; i++) step(7, 2'd1, 0, 0, "wait2_hold");
      fifo_empty = 3'b111;
      step(1, 2'd1, 0, 0, "wait2_lfd");
      step(2, 2'd1, 0, 0, "wait2_ld");

      // Soft reset: only the selected port matters
      soft_reset = 3'b001;
      step(2, 2'd1, 0, 0, "sr_other");
      soft_reset = 3'b010;
      step(0, 2'd1, 0, 0, "sr_own");
      soft_reset = 3'b000; pkt_valid = 1'b0;
      step(0, 2'd1, 0, 0, "sr_idle");

      // Reset mid-packet during full stall
      pkt_valid = 1'b1; data_in = 2'd2;
      step(1, 2'd2, 0, 0, "rst_lfd");
      step(2, 2'd2, 0, 0, "rst_ld");
      fifo_full = 1'b1;
      step(3, 2'd2, 0, 0, "rst_full");
      resetn = 1'b0;
      step(0, 2'd3, 0, 0, "rst_applied");
      resetn = 1'b1; fifo_full = 1'b0; pkt_valid = 1'b0;
      step(0, 2'd3, 0, 0, "rst_idle");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
